// File: rtl/clock_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clock_div_pkg;

    localparam int unsigned MIN_DIV       = 2;
    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] div_t;

endpackage

// File: rtl/clock_div_prog_if.sv
// Divisor load / status bundle between a rate controller and clock_div_prog.
interface clock_div_prog_if
    import clock_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic             pending;

    modport master (
        output div_in,
        output div_load,
        input  div_ack,
        input  div_err,
        input  pending
    );

    modport slave (
        input  div_in,
        input  div_load,
        output div_ack,
        output div_err,
        output pending
    );

endinterface

// File: rtl/clock_div_phase.sv
// Dual-edge output stage: negedge half-cycle extension for odd divisors plus the output OR.
module clock_div_phase (
    input  logic clk_in,
    input  logic rst,
    input  logic pos_hi,
    input  logic odd,
    output logic clk_out
);

    logic neg_hi;

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            neg_hi <= 1'b0;
        end else begin
            neg_hi <= pos_hi;
        end
    end

    // Pure flop-output OR; neg_hi is already low at every period boundary
    assign clk_out = pos_hi | (odd & neg_hi);

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable 50%-duty clock divider, divisor switches only at period boundaries.
// Optional CLK_DIV_TICK_EN adds a clk_in-domain strobe aligned to each clk_out rise.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    clock_div_prog_if.slave  bus,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(MIN_DIV);

    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_pend;
    logic [WIDTH-1:0] cnt;
    logic             pend_v;
    logic             pos_hi;
    logic             ack_q;
    logic             err_q;

    logic [WIDTH-1:0] n_act_nx;
    logic [WIDTH-1:0] cnt_nx;
    logic             at_last;
    logic             boundary;
    logic             load_ok;
    logic             load_bad;

    always_comb begin
        at_last  = 1'b0;
        boundary = 1'b0;
        load_ok  = 1'b0;
        load_bad = 1'b0;
        n_act_nx = n_act;
        cnt_nx   = cnt + WIDTH'(1);

        at_last  = (cnt == (n_act - WIDTH'(1)));
        boundary = at_last && pend_v;
        load_ok  = bus.div_load && (bus.div_in >= DIV_MIN);
        load_bad = bus.div_load && (bus.div_in <  DIV_MIN);

        if (boundary) begin
            n_act_nx = n_pend;
        end
        if (at_last) begin
            cnt_nx = '0;
        end
    end

    // Counter, phase flop and divisor hand-over share one register stage
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            n_act  <= DIV_RST;
            n_pend <= DIV_RST;
            cnt    <= DIV_RST - WIDTH'(1);
            pend_v <= 1'b0;
            pos_hi <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            n_act  <= n_act_nx;
            cnt    <= cnt_nx;
            pos_hi <= (cnt_nx < (n_act_nx >> 1));
            ack_q  <= boundary;
            err_q  <= load_bad;
            // A load landing on the boundary is queued for the next one
            if (load_ok) begin
                n_pend <= bus.div_in;
                pend_v <= 1'b1;
            end else if (boundary) begin
                pend_v <= 1'b0;
            end
        end
    end

    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
    assign bus.pending = pend_v;

    clock_div_phase u_phase (
        .clk_in  (clk_in),
        .rst     (rst),
        .pos_hi  (pos_hi),
        .odd     (n_act[0]),
        .clk_out (clk_out)
    );

`ifdef CLK_DIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_nx == '0);
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule
